// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types and helpers for the clock-enable generator
package clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_RUN,
    ST_RECONF
  } gen_state_t;

  // Record fields are sized for the widest supported build; users slice them down.
  localparam int CFG_CH_W_MAX  = 8;
  localparam int CFG_DIV_W_MAX = 32;

  typedef struct packed {
    logic [CFG_CH_W_MAX-1:0]  ch;
    logic [CFG_DIV_W_MAX-1:0] div;
    logic [CFG_DIV_W_MAX-1:0] phase;
  } cfg_rec_t;

  function automatic int chan_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// rtl/clk_gen_chan.sv - one divided channel: period counter, ratio register, tick/level decode
module clk_gen_chan #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_en,
  input  logic [DIV_W-1:0] load_div,
  input  logic [DIV_W-1:0] load_cnt,
  output logic             wrap,
  output logic             tick,
  output logic             outclk
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  // A load only ever coincides with the last cycle of the old period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      div <= DEF_DIV;
    end else if (load_en) begin
      cnt <= load_cnt;
      div <= load_div;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign wrap   = (cnt == div - DIV_W'(1));
  assign tick   = en && (cnt == '0);
  assign outclk = en && (cnt < (div >> 1));

endmodule

// File: rtl/clk_gen_div.sv
// rtl/clk_gen_div.sv - multi-channel clock-enable generator with runtime reprogramming and lock
module clk_gen_div
  import clk_gen_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      DIV_W       = 16,
  parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV     = {16'd10, 16'd2},
  parameter int                      LOCK_CYCLES = 16,
  localparam int                     CH_W        = chan_w(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  gen_state_t        state;
  gen_state_t        state_next;
  logic [SET_W-1:0]  settle_cnt;
  logic              started;
  cfg_rec_t          pend;
  logic [CH_W-1:0]   pend_ch;
  logic [NUM_CH-1:0] wrap;
  logic              accept;
  logic              bad_req;
  logic              load_req;
  logic              unused_pend;

  assign pend_ch     = pend.ch[CH_W-1:0];
  assign unused_pend = ^{pend.ch, pend.div, pend.phase};

  assign cfg_ready = (state == ST_RUN);
  assign locked    = (state == ST_RUN);
  assign accept    = cfg_valid && cfg_ready;
  assign bad_req   = (cfg_div < DIV_W'(2)) || (cfg_phase >= cfg_div) || (int'(cfg_ch) >= NUM_CH);

  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    unique case (state)
      ST_SETTLE: if (settle_cnt == SET_W'(LOCK_CYCLES - 1)) state_next = ST_RUN;
      ST_RUN:    if (accept && !bad_req) state_next = ST_RECONF;
      ST_RECONF: begin
        // Switch over only at the target's period boundary so no short pulse escapes.
        if (wrap[pend_ch]) begin
          load_req   = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      default:   state_next = ST_SETTLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      started    <= 1'b0;
      cfg_err    <= 1'b0;
      pend       <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= (state == ST_SETTLE && state_next == ST_SETTLE) ? settle_cnt + SET_W'(1) : '0;
      if (state == ST_SETTLE && state_next == ST_RUN) started <= 1'b1;
      cfg_err    <= accept && bad_req;
      if (accept && !bad_req) begin
        pend <= '{ch:    CFG_CH_W_MAX'(cfg_ch),
                  div:   CFG_DIV_W_MAX'(cfg_div),
                  phase: CFG_DIV_W_MAX'(cfg_phase)};
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_gen_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV[i*DIV_W +: DIV_W])
    ) u_chan (
      .clk      (refclk),
      .rst      (rst),
      .en       (started),
      .load_en  (load_req && (pend_ch == CH_W'(i))),
      .load_div (pend.div[DIV_W-1:0]),
      .load_cnt (pend.phase[DIV_W-1:0]),
      .wrap     (wrap[i]),
      .tick     (tick[i]),
      .outclk   (outclk[i])
    );
  end

endmodule

// File: tb/tb_clk_gen_div.sv
// tb/tb_clk_gen_div.sv - scoreboard bench for the clock-enable generator
module tb_clk_gen_div;

  localparam int LOCK = 16;

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic        rst;
  logic        a_valid, a_ready, a_err, a_locked;
  logic [0:0]  a_ch;
  logic [15:0] a_div, a_phase;
  logic [1:0]  a_outclk, a_tick;
  logic        b_valid, b_ready, b_err, b_locked;
  logic [1:0]  b_ch;
  logic [7:0]  b_div, b_phase;
  logic [3:0]  b_outclk, b_tick;

  clk_gen_div u_dut_a (
    .refclk(refclk), .rst(rst), .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_ch(a_ch),
    .cfg_div(a_div), .cfg_phase(a_phase), .cfg_err(a_err), .outclk(a_outclk), .tick(a_tick),
    .locked(a_locked)
  );

  clk_gen_div #(
    .NUM_CH(4), .DIV_W(8), .DEF_DIV({8'd6, 8'd4, 8'd3, 8'd2}), .LOCK_CYCLES(LOCK)
  ) u_dut_b (
    .refclk(refclk), .rst(rst), .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_ch(b_ch),
    .cfg_div(b_div), .cfg_phase(b_phase), .cfg_err(b_err), .outclk(b_outclk), .tick(b_tick),
    .locked(b_locked)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;
  int base_k[2];
  int base_cnt[2];
  int mdiv[2];
  logic [6:0] sb_q[$];

  task automatic step();
    @(posedge refclk);
    #1;
    k++;
  endtask

  function automatic int exp_cnt(int ch, int kk);
    return (base_cnt[ch] + kk - base_k[ch]) % mdiv[ch];
  endfunction

  // {cfg_err, locked, cfg_ready, outclk[1:0], tick[1:0]} of DUT A after edge kk
  function automatic logic [6:0] exp_vec(int kk, bit lk, bit err);
    logic [1:0] oc, tk;
    int c;
    for (int i = 0; i < 2; i++) begin
      c     = exp_cnt(i, kk);
      oc[i] = (kk >= LOCK) && (c < mdiv[i] / 2);
      tk[i] = (kk >= LOCK) && (c == 0);
    end
    return {err, lk, lk, oc, tk};
  endfunction

  task automatic test_reset();
    logic [6:0] got, exp_v;
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (3) step();
    got = {a_err, a_locked, a_ready, a_outclk, a_tick};
    checks++;
    if (got !== 7'b0) begin errors++; $display("FAIL reset_outputs_a got=%b exp=0000000", got); end
    checks++;
    if ({b_err, b_locked, b_ready, b_outclk, b_tick} !== 11'b0)
      begin errors++; $display("FAIL reset_outputs_b got=%b exp=0", {b_err, b_locked, b_ready, b_outclk, b_tick}); end
    rst = 1'b0;
    k = 0;
    base_k = '{0, 0};
    base_cnt = '{0, 0};
    mdiv = '{2, 10};
    for (int n = 1; n <= LOCK + 30; n++) begin
      sb_q.push_back(exp_vec(n, n >= LOCK, 1'b0));
      step();
      exp_v = sb_q.pop_front();
      got = {a_err, a_locked, a_ready, a_outclk, a_tick};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL lock_seq k=%0d got=%b exp=%b", k, got, exp_v); end
      checks++;
      if (b_locked !== (k >= LOCK)) begin errors++; $display("FAIL lock_b k=%0d got=%b exp=%b", k, b_locked, k >= LOCK); end
    end
  endtask

  task automatic test_reconfig(int ch, int div, int phase, int at_cnt);
    logic [6:0] got, exp_v;
    int ka, es, guard;
    guard = 0;
    if (at_cnt >= 0)
      while (exp_cnt(ch, k) != at_cnt && guard < 50) begin step(); guard++; end
    a_ch = 1'(ch);
    a_div = 16'(div);
    a_phase = 16'(phase);
    a_valid = 1'b1;
    ka = k + 1;
    sb_q.push_back(exp_vec(ka, 1'b0, 1'b0));
    step();
    a_valid = 1'b0;
    exp_v = sb_q.pop_front();
    got = {a_err, a_locked, a_ready, a_outclk, a_tick};
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reconf_accept ch=%0d got=%b exp=%b", ch, got, exp_v); end
    es = ka + 1;
    while (exp_cnt(ch, es - 1) != mdiv[ch] - 1) es++;
    for (int n = ka + 1; n <= es + LOCK + 12; n++) begin
      if (n == es) begin base_k[ch] = es; base_cnt[ch] = phase; mdiv[ch] = div; end
      sb_q.push_back(exp_vec(n, n >= es + LOCK, 1'b0));
      step();
      exp_v = sb_q.pop_front();
      got = {a_err, a_locked, a_ready, a_outclk, a_tick};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reconf_seq ch=%0d k=%0d sw=%0d got=%b exp=%b", ch, k, es, got, exp_v); end
    end
  endtask

  task automatic test_cfg_err();
    logic [6:0] got, exp_v;
    logic [15:0] bad_div[3];
    logic [15:0] bad_phase[3];
    bad_div = '{16'd1, 16'd5, 16'd0};
    bad_phase = '{16'd0, 16'd5, 16'd0};
    for (int j = 0; j < 3; j++) begin
      a_ch = 1'(j & 1);
      a_div = bad_div[j];
      a_phase = bad_phase[j];
      a_valid = 1'b1;
      sb_q.push_back(exp_vec(k + 1, 1'b1, 1'b1));
      step();
      a_valid = 1'b0;
      exp_v = sb_q.pop_front();
      got = {a_err, a_locked, a_ready, a_outclk, a_tick};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL err_pulse j=%0d got=%b exp=%b", j, got, exp_v); end
      for (int n = 0; n < 8; n++) begin
        sb_q.push_back(exp_vec(k + 1, 1'b1, 1'b0));
        step();
        exp_v = sb_q.pop_front();
        got = {a_err, a_locked, a_ready, a_outclk, a_tick};
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL err_after j=%0d k=%0d got=%b exp=%b", j, k, got, exp_v); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (exp_cnt(1, k) != 0 && guard < 20) begin step(); guard++; end
    a_ch = 1'b1;
    a_div = 16'd6;
    a_phase = 16'd1;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({a_locked, a_ready} !== 2'b00) begin errors++; $display("FAIL reconf_hold n=%0d got=%b exp=00", n, {a_locked, a_ready}); end
      if (n < 2) step();
    end
    test_reset();
  endtask

  task automatic test_back_to_back();
    logic [6:0] got, exp_v;
    int ka, es, guard;
    bit lk, oc3;
    b_ch = 2'd3;
    b_div = 8'd3;
    b_phase = 8'd0;
    b_valid = 1'b1;
    ka = k + 1;
    step();
    checks++;
    if ({b_locked, b_ready} !== 2'b00) begin errors++; $display("FAIL b2b_accept got=%b exp=00", {b_locked, b_ready}); end
    b_ch = 2'd2;
    b_div = 8'd5;
    es = ka + 1;
    while ((es - 1) % 6 != 5) es++;
    for (int n = ka + 1; n <= es + LOCK + 1; n++) begin
      lk = (n == es + LOCK);
      oc3 = (n >= es) ? ((n - es) % 3 == 0) : ((n % 6) < 3);
      sb_q.push_back({1'b0, lk, lk, 3'b000, oc3});
      step();
      exp_v = sb_q.pop_front();
      got = {b_err, b_locked, b_ready, 3'b000, b_outclk[3]};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL b2b_seq k=%0d sw=%0d got=%b exp=%b", k, es, got, exp_v); end
    end
    b_valid = 1'b0;
    guard = 0;
    while (b_locked !== 1'b1 && guard < 60) begin step(); guard++; end
    checks++;
    if (b_locked !== 1'b1) begin errors++; $display("FAIL b2b_relock got=%b exp=1 after %0d cycles", b_locked, guard); end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_ch = '0; a_div = '0; a_phase = '0;
    b_valid = 1'b0; b_ch = '0; b_div = '0; b_phase = '0;
    test_reset();
    test_reconfig(1, 4, 0, 3);
    test_cfg_err();
    test_reconfig(0, 5, 3, -1);
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
